// File: rtl/router_pkg.sv
// router_pkg: shared defaults and channel state encoding for the sync router.
package router_pkg;
    localparam int DEF_NUM_CH  = 3;
    localparam int DEF_ADDR_W  = 2;
    localparam int DEF_TIMEOUT = 30;
    typedef enum logic [1:0] {CH_IDLE, CH_WAIT, CH_FLUSH} ch_state_t;
endpackage

// File: rtl/router_sync_n_if.sv
// router_sync_n_if: header/FIFO-side signals of the sync router; slave is the router.
interface router_sync_n_if
    import router_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              detect_add;
    logic [ADDR_W-1:0] data_in;
    logic              write_enb_reg;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] read_enb;
    logic [NUM_CH-1:0] write_enb;
    logic              fifo_full;
    logic [NUM_CH-1:0] vld_out;
    logic [NUM_CH-1:0] soft_reset;
    logic              addr_err;
    logic [ADDR_W-1:0] active_ch;
    modport master (
        output detect_add, data_in, write_enb_reg, full, empty, read_enb,
        input  write_enb, fifo_full, vld_out, soft_reset, addr_err, active_ch
    );
    modport slave (
        input  detect_add, data_in, write_enb_reg, full, empty, read_enb,
        output write_enb, fifo_full, vld_out, soft_reset, addr_err, active_ch
    );
endinterface

// File: rtl/router_sync_timer.sv
// router_sync_timer: per-channel unread-data watchdog issuing a one-cycle FIFO flush pulse.
module router_sync_timer
    import router_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clock,
    input  logic reset,
    input  logic vld,
    input  logic rd,
    output logic soft_reset
);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [1:0] IDLE  = CH_IDLE;
    localparam logic [1:0] WAIT  = CH_WAIT;
    localparam logic [1:0] FLUSH = CH_FLUSH;

    if (TIMEOUT < 2 || TIMEOUT > 1023) begin : g_bad_timeout
        $error("router_sync_timer: TIMEOUT out of range");
    end

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             waiting;

    assign waiting = vld & ~rd;

    // A read on the terminal-count edge wins: the WAIT branch leaves before the count test.
    always_ff @(posedge clock) begin
        soft_reset <= 1'b0;
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (waiting) begin
                    state <= WAIT;
                    cnt   <= CNT_W'(1);
                end
                WAIT: if (!waiting) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else if (cnt == LAST) begin
                    state      <= FLUSH;
                    cnt        <= '0;
                    soft_reset <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                FLUSH: begin
                    cnt <= '0;
                    if (!vld || rd) state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: rtl/router_sync_n.sv
// router_sync_n: latches the header destination, steers FIFO writes and
// runs one watchdog per channel to flush stale FIFOs.
module router_sync_n
    import router_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input logic           clock,
    input logic           reset,
    router_sync_n_if.slave bus
);
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(NUM_CH);

    if (NUM_CH < 2 || NUM_CH > 2 ** ADDR_W) begin : g_bad_num_ch
        $error("router_sync_n: NUM_CH out of range for ADDR_W");
    end

    logic              dest_ok;
    logic [NUM_CH-1:0] sr;

    assign dest_ok        = {1'b0, bus.active_ch} < LIMIT;
    assign bus.write_enb  = (bus.write_enb_reg && dest_ok) ? NUM_CH'(1'b1) << bus.active_ch : '0;
    assign bus.fifo_full  = dest_ok & bus.full[bus.active_ch];
    assign bus.vld_out    = ~bus.empty;
    assign bus.soft_reset = sr;

    always_ff @(posedge clock) begin
        if (reset) begin
            bus.active_ch <= '0;
            bus.addr_err  <= 1'b0;
        end else begin
            if (bus.detect_add) bus.active_ch <= bus.data_in;
            bus.addr_err <= bus.detect_add && ({1'b0, bus.data_in} >= LIMIT);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        router_sync_timer #(.TIMEOUT(TIMEOUT)) u_timer (
            .clock      (clock),
            .reset      (reset),
            .vld        (bus.vld_out[i]),
            .rd         (bus.read_enb[i]),
            .soft_reset (sr[i])
        );
    end
endmodule

// File: tb/tb_router_sync_n.sv
// tb_router_sync_n: directed stimulus with queued expectations checked by a negedge monitor.
module tb_router_sync_n;
    typedef struct {
        int         tag;
        logic [2:0] we;
        logic       ff;
        logic [1:0] ac;
        logic [2:0] vld;
    } comb_t;
    typedef struct {
        int         tag;
        logic [2:0] s0;
        logic       ae;
        logic [3:0] s1;
    } pulse_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    comb_t  cq[$];
    pulse_t pq[$];
    comb_t  ce;
    pulse_t pe;

    router_sync_n_if #(.NUM_CH(3), .ADDR_W(2)) a();
    router_sync_n_if #(.NUM_CH(4), .ADDR_W(2)) b();

    router_sync_n #(.NUM_CH(3), .ADDR_W(2), .TIMEOUT(30)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (a.slave)
    );
    router_sync_n #(.NUM_CH(4), .ADDR_W(2), .TIMEOUT(5)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (b.slave)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic exp_comb(input logic [2:0] we, input logic ff, input logic [1:0] ac, input logic [2:0] vld);
        cq.push_back('{cyc, we, ff, ac, vld});
    endtask

    task automatic exp_pulse(input logic [2:0] s0, input logic ae, input logic [3:0] s1);
        pq.push_back('{cyc, s0, ae, s1});
    endtask

    always @(negedge clock) begin
        while (cq.size() > 0 && cq[0].tag <= cyc) begin
            ce = cq.pop_front();
            checks++;
            if (ce.tag < cyc) begin
                errors++;
                $display("FAIL comb_missed tag=%0d cyc=%0d", ce.tag, cyc);
            end else if ({a.write_enb, a.fifo_full, a.active_ch, a.vld_out} !== {ce.we, ce.ff, ce.ac, ce.vld}) begin
                errors++;
                $display("FAIL comb cyc=%0d got we=%b ff=%b ac=%0d vld=%b exp we=%b ff=%b ac=%0d vld=%b",
                         cyc, a.write_enb, a.fifo_full, a.active_ch, a.vld_out, ce.we, ce.ff, ce.ac, ce.vld);
            end
        end
        if (a.soft_reset != 0 || a.addr_err || b.soft_reset != 0) begin
            checks++;
            if (pq.size() == 0 || pq[0].tag != cyc) begin
                errors++;
                $display("FAIL pulse_unexpected cyc=%0d got sr_a=%b ae=%b sr_b=%b exp none",
                         cyc, a.soft_reset, a.addr_err, b.soft_reset);
            end else begin
                pe = pq.pop_front();
                if ({a.soft_reset, a.addr_err, b.soft_reset} !== {pe.s0, pe.ae, pe.s1}) begin
                    errors++;
                    $display("FAIL pulse cyc=%0d got sr_a=%b ae=%b sr_b=%b exp sr_a=%b ae=%b sr_b=%b",
                             cyc, a.soft_reset, a.addr_err, b.soft_reset, pe.s0, pe.ae, pe.s1);
                end
            end
        end
        while (pq.size() > 0 && pq[0].tag < cyc) begin
            pe = pq.pop_front();
            checks++;
            errors++;
            $display("FAIL pulse_missed tag=%0d exp sr_a=%b ae=%b sr_b=%b got none", pe.tag, pe.s0, pe.ae, pe.s1);
        end
    end

    initial begin
        a.detect_add = 1'b0; a.data_in = '0; a.write_enb_reg = 1'b0;
        a.full = '0; a.empty = '1; a.read_enb = '0;
        b.detect_add = 1'b0; b.data_in = '0; b.write_enb_reg = 1'b0;
        b.full = '0; b.empty = '1; b.read_enb = '0;
        step(2);
        reset = 1'b0;
        a.write_enb_reg = 1'b1; a.full = 3'b001;
        exp_comb(3'b001, 1'b1, 2'd0, 3'b000);
        step();
        a.detect_add = 1'b1; a.data_in = 2'd2; a.write_enb_reg = 1'b0;
        exp_comb(3'b000, 1'b1, 2'd0, 3'b000);
        step();
        a.detect_add = 1'b0; a.write_enb_reg = 1'b1; a.full = 3'b100;
        exp_comb(3'b100, 1'b1, 2'd2, 3'b000);
        step();
        a.full = 3'b011;
        exp_comb(3'b100, 1'b0, 2'd2, 3'b000);
        step();
        a.detect_add = 1'b1; a.data_in = 2'd3;
        step();
        a.detect_add = 1'b0; a.full = 3'b111;
        exp_pulse(3'b000, 1'b1, 4'b0000);
        exp_comb(3'b000, 1'b0, 2'd3, 3'b000);
        step();
        exp_comb(3'b000, 1'b0, 2'd3, 3'b000);
        a.detect_add = 1'b1; a.data_in = 2'd1;
        step();
        a.detect_add = 1'b0;
        exp_comb(3'b010, 1'b1, 2'd1, 3'b000);
        step();
        a.write_enb_reg = 1'b0; a.full = '0;
        a.empty = 3'b010; a.read_enb = 3'b101;
        exp_comb(3'b000, 1'b0, 2'd1, 3'b101);
        step();
        a.empty = 3'b111; a.read_enb = '0;
        step();
        // channel 1 times out, sits in flush, then times out again after draining
        a.empty = 3'b101;
        exp_comb(3'b000, 1'b0, 2'd1, 3'b010);
        step(30);
        exp_pulse(3'b010, 1'b0, 4'b0000);
        step(5);
        a.empty = 3'b111;
        step();
        a.empty = 3'b101;
        step(30);
        exp_pulse(3'b010, 1'b0, 4'b0000);
        a.empty = 3'b111;
        step();
        // read on the terminal edge suppresses the pulse on channel 0
        a.empty = 3'b110;
        step(29);
        a.read_enb = 3'b001;
        step();
        a.read_enb = '0;
        step(30);
        exp_pulse(3'b001, 1'b0, 4'b0000);
        a.empty = 3'b111;
        step();
        // reset mid-count on channel 2 restarts the full wait
        a.empty = 3'b011;
        step(19);
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_comb(3'b000, 1'b0, 2'd0, 3'b100);
        step(30);
        exp_pulse(3'b100, 1'b0, 4'b0000);
        a.empty = 3'b111;
        step();
        b.empty = 4'b0000;
        step(5);
        exp_pulse(3'b000, 1'b0, 4'b1111);
        b.empty = 4'b1111;
        step(3);
        checks++;
        if (cq.size() != 0 || pq.size() != 0) begin
            errors++;
            $display("FAIL leftover got comb=%0d pulse=%0d exp 0 0", cq.size(), pq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/router_sync_n.md
ROUTER_SYNC_N -- requirements
Module: router_sync_n

Interface
REQ-001 SHALL have parameter NUM_CH, default 3: number of destination channels/FIFOs, range 2..2**ADDR_W.
REQ-002 SHALL have parameter ADDR_W, default 2: width of the destination address field.
REQ-003 SHALL have parameter TIMEOUT, default 30: consecutive unread-valid cycles before a channel soft reset, range 2..1023.
REQ-004 SHALL have derived local parameter CNT_W = clog2(TIMEOUT), the timeout counter width.
REQ-005 clock  in  1  single clock; all state updates on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 detect_add  in  1  header byte present; capture data_in as the destination.
REQ-008 data_in  in  ADDR_W  destination address from the header.
REQ-009 write_enb_reg  in  1  FSM request to write the current byte.
REQ-010 full  in  NUM_CH  per-FIFO full flags.
REQ-011 empty  in  NUM_CH  per-FIFO empty flags.
REQ-012 read_enb  in  NUM_CH  per-channel downstream read strobes.
REQ-013 write_enb  out  NUM_CH  one-hot FIFO write enables.
REQ-014 fifo_full  out  1  full flag of the selected FIFO.
REQ-015 vld_out  out  NUM_CH  per-channel data-valid.
REQ-016 soft_reset  out  NUM_CH  per-channel one-cycle FIFO flush pulse.
REQ-017 addr_err  out  1  one-cycle pulse flagging an out-of-range destination.
REQ-018 active_ch  out  ADDR_W  currently latched destination.

Function
REQ-019 active_ch SHALL load data_in on a rising edge with detect_add=1 and hold otherwise; the new value takes effect in the following cycle.
REQ-020 A destination SHALL be valid iff active_ch < NUM_CH.
REQ-021 write_enb SHALL be combinational: bit active_ch set iff write_enb_reg=1 and the destination is valid; otherwise all zero. Write_enb SHALL never have more than one bit set.
REQ-022 fifo_full SHALL be combinationally full[active_ch] for a valid destination, and 0 otherwise.
REQ-023 addr_err SHALL be registered and high for exactly the one cycle after an edge where detect_add=1 and data_in >= NUM_CH.
REQ-024 vld_out[i] SHALL equal ~empty[i] combinationally.
REQ-025 Each channel SHALL run an independent state machine with states IDLE, WAIT and FLUSH, plus a CNT_W-bit counter.
REQ-026 IDLE -> WAIT on an edge with vld_out[i]=1 and read_enb[i]=0; the counter becomes 1.
REQ-027 In WAIT, each edge with vld_out[i]=1 and read_enb[i]=0 SHALL increment the counter.
REQ-028 In WAIT, an edge with read_enb[i]=1 or vld_out[i]=0 SHALL clear the counter and return to IDLE, with no soft_reset.
REQ-029 In WAIT, a waiting edge with counter = TIMEOUT-1 SHALL set soft_reset[i]=1 for exactly the next cycle, clear the counter and enter FLUSH.
REQ-030 read_enb[i]=1 on the terminal-count edge SHALL take priority: no soft_reset is asserted and the channel returns to IDLE.
REQ-031 In FLUSH, the counter SHALL hold at 0; empty[i]=1 or read_enb[i]=1 SHALL return the channel to IDLE, and no further soft_reset is issued while in FLUSH.
REQ-032 Channel state machines SHALL be independent; simultaneous timeouts on several channels SHALL produce simultaneous pulses.
REQ-033 The counter SHALL never wrap and never exceed TIMEOUT-1.

Reset
REQ-034 While reset=1 at an edge: active_ch=0, addr_err=0, soft_reset=0, all counters 0, all channels IDLE.
REQ-035 Reset mid-count or in FLUSH SHALL abort without any soft_reset pulse.
REQ-036 Combinational outputs SHALL follow their inputs during reset; after reset write_enb and fifo_full reflect channel 0.

Structure
REQ-037 Package router_pkg SHALL hold the channel state enum and the default values of NUM_CH, ADDR_W and TIMEOUT.
REQ-038 The per-channel state machine and counter SHALL be sub-module router_sync_timer (parameter TIMEOUT), generated NUM_CH times.
REQ-039 Parameter legality (NUM_CH <= 2**ADDR_W, TIMEOUT >= 2) SHALL be checked at elaboration.

Verification (defaults unless noted)
REQ-040 detect_add with data_in=2, then write_enb_reg=1 -> write_enb=100; with full=100, fifo_full=1.
REQ-041 detect_add with data_in=3 -> addr_err high for one cycle; write_enb=000 and fifo_full=0 while write_enb_reg=1.
REQ-042 empty[1]=0 and read_enb[1]=0 for 30 edges -> soft_reset[1]=1 for exactly one cycle after edge 30; channel then in FLUSH until empty[1]=1.
REQ-043 read_enb[0] pulsed on edge 30 of a wait -> no soft_reset[0]; a later 30-cycle wait does pulse.
REQ-044 reset asserted on edge 20 of a wait -> counter 0, no pulse; after release, a full 30 new waiting edges are needed for a pulse.
REQ-045 NUM_CH=4, TIMEOUT=5: all channels waiting from the same edge -> soft_reset=1111 for one cycle after edge 5.
